// File: rtl/range_pkg.sv
// Shared types and default sizing for the range sequence driver.
package range_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      STREAM = 2'd2,
      RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/range_seq_driver_if.sv
// Sample-loading, transmit and response signals between the driver and its host/range finder.
interface range_seq_driver_if
   import range_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [CW-1:0]    count;
   logic             full;
   logic             overflow;
   logic             start;
   logic             start_rej;
   logic             busy;
   logic [WIDTH-1:0] data_out;
   logic             go;
   logic             finish;
   logic [WIDTH-1:0] range_in;
   logic             error_in;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             result_err;
   logic             mismatch;

   modport master (
      output wr_en, wr_data, start, range_in, error_in,
      input  count, full, overflow, start_rej, busy, data_out, go, finish,
             done, result, result_err, mismatch
   );

   modport slave (
      input  wr_en, wr_data, start, range_in, error_in,
      output count, full, overflow, start_rej, busy, data_out, go, finish,
             done, result, result_err, mismatch
   );

endinterface

// File: rtl/range_fifo.sv
// Synchronous sample FIFO with registered read; the storage array carries no reset.
module range_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             do_push, do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CW'(1);
      else if (!do_push && do_pop)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
      if (do_pop)  rd_data_q <= mem[rd_ptr_q];
   end

   assign rd_data = rd_data_q;
   assign count   = count_q;
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/range_seq_driver.sv
// Buffers samples, streams them to a range finder with go/finish strobes and
// checks the returned range against a locally tracked max-min.
module range_seq_driver
   import range_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input logic                clk,
   input logic                rst_n,
   range_seq_driver_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   state_e           state_q, state_d;
   logic             push, pop, drop, accept, reject, last_pop, capture;
   logic             fifo_full, fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [WIDTH-1:0] fifo_rd;

   logic             overflow_q, start_rej_q, busy_q, go_q, finish_q, done_q;
   logic             result_err_q, mismatch_q;
   logic [WIDTH-1:0] data_out_q, result_q, min_q, max_q;
   logic             pop_v_q, pop_first_q, pop_last_q, fin_dly_q;

   range_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (bus.wr_data),
      .pop     (pop),
      .rd_data (fifo_rd),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Start is judged on the registered count, i.e. before a same-cycle push.
   assign push     = (state_q == IDLE) && bus.wr_en && !fifo_full;
   assign drop     = (state_q == IDLE) && bus.wr_en && fifo_full;
   assign accept   = (state_q == IDLE) && bus.start && !busy_q && (fifo_count >= CW'(2));
   assign reject   = (state_q == IDLE) && bus.start && !busy_q && (fifo_count < CW'(2));
   assign pop      = (state_q == FIRST) || ((state_q == STREAM) && !fifo_empty);
   assign last_pop = pop && (fifo_count == CW'(1));
   assign capture  = (state_q == RESP) && fin_dly_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = FIRST;
         FIRST:   state_d = STREAM;
         STREAM:  if (last_pop) state_d = RESP;
         RESP:    if (capture) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         overflow_q   <= 1'b0;
         start_rej_q  <= 1'b0;
         busy_q       <= 1'b0;
         data_out_q   <= '0;
         go_q         <= 1'b0;
         finish_q     <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
         result_err_q <= 1'b0;
         mismatch_q   <= 1'b0;
         min_q        <= '0;
         max_q        <= '0;
         pop_v_q      <= 1'b0;
         pop_first_q  <= 1'b0;
         pop_last_q   <= 1'b0;
         fin_dly_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_rej_q <= reject;
         if (accept)    overflow_q <= 1'b0;
         else if (drop) overflow_q <= 1'b1;
         if (accept)      busy_q <= 1'b1;
         else if (done_q) busy_q <= 1'b0;

         // FIFO read data lags the pop by one edge, so strobes are pipelined alongside it.
         pop_v_q     <= pop;
         pop_first_q <= (state_q == FIRST);
         pop_last_q  <= last_pop;
         if (pop_v_q) begin
            data_out_q <= fifo_rd;
            go_q       <= pop_first_q;
            finish_q   <= pop_last_q;
            if (pop_first_q) begin
               min_q <= fifo_rd;
               max_q <= fifo_rd;
            end else begin
               if (fifo_rd < min_q) min_q <= fifo_rd;
               if (fifo_rd > max_q) max_q <= fifo_rd;
            end
         end else begin
            data_out_q <= '0;
            go_q       <= 1'b0;
            finish_q   <= 1'b0;
         end

         fin_dly_q <= finish_q;
         done_q    <= capture;
         if (capture) begin
            result_q     <= bus.range_in;
            result_err_q <= bus.error_in;
            mismatch_q   <= bus.error_in || (bus.range_in != (max_q - min_q));
         end
      end
   end

   assign bus.count      = fifo_count;
   assign bus.full       = fifo_full;
   assign bus.overflow   = overflow_q;
   assign bus.start_rej  = start_rej_q;
   assign bus.busy       = busy_q;
   assign bus.data_out   = data_out_q;
   assign bus.go         = go_q;
   assign bus.finish     = finish_q;
   assign bus.done       = done_q;
   assign bus.result     = result_q;
   assign bus.result_err = result_err_q;
   assign bus.mismatch   = mismatch_q;

endmodule
